// File: rtl/cascade_rdseq_if.sv
// Buffer-read and downstream-stream signal bundle for the FFT cascade read sequencer.
// master = sequencer side, slave = buffer/downstream side.
interface cascade_rdseq_if #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                          buf_ready;
    logic [ADDR_WIDTH-1:0]         buf_rdaddr;
    logic signed [DATA_WIDTH-1:0]  buf_Re;
    logic signed [DATA_WIDTH-1:0]  buf_Im;
    logic                          buf_rdack;
    logic signed [DATA_WIDTH-1:0]  out_Re;
    logic signed [DATA_WIDTH-1:0]  out_Im;
    logic                          out_valid;
    logic                          out_sop;
    logic                          out_eop;
    logic                          out_ready;
    logic                          busy;
    logic [15:0]                   frame_cnt;

    modport master (
        input  buf_ready, buf_Re, buf_Im, out_ready,
        output buf_rdaddr, buf_rdack, out_Re, out_Im, out_valid, out_sop, out_eop,
               busy, frame_cnt
    );

    modport slave (
        output buf_ready, buf_Re, buf_Im, out_ready,
        input  buf_rdaddr, buf_rdack, out_Re, out_Im, out_valid, out_sop, out_eop,
               busy, frame_cnt
    );
endinterface

// File: rtl/cascade_rdseq.sv
// Read sequencer for the bit-reversal ping-pong buffer: sweeps one frame out of the
// buffer and streams it downstream through a 2-entry skid FIFO, then acks the buffer.
module cascade_rdseq #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic             clk,
    input  logic             aclr_n,
    cascade_rdseq_if.master  io
);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_ACK} state_t;

    typedef struct packed {
        logic                         sop;
        logic                         eop;
        logic signed [DATA_WIDTH-1:0] re;
        logic signed [DATA_WIDTH-1:0] im;
    } word_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_infl;
    logic                  r_infl_sop;
    logic                  r_infl_eop;
    word_t                 r_head;
    word_t                 r_skid;
    logic                  r_head_vld;
    logic                  r_skid_vld;
    logic                  r_rdack;
    logic                  r_busy;
    logic [15:0]           r_frame_cnt;
    logic                  w_pop;
    logic                  w_issue;
    logic [1:0]            w_occ;
    word_t                 w_push;

    // Occupancy counts the word still in the buffer's read pipe so the skid never overflows.
    assign w_pop   = r_head_vld && io.out_ready;
    assign w_occ   = 2'(r_head_vld) + 2'(r_skid_vld) + 2'(r_infl) - 2'(w_pop);
    assign w_issue = (r_state == S_READ) && (w_occ < 2'd2);
    assign w_push  = '{sop: r_infl_sop, eop: r_infl_eop, re: io.buf_Re, im: io.buf_Im};

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (io.buf_ready) w_next = S_READ;
            S_READ:  if (w_issue && (r_addr == ADDR_LAST)) w_next = S_DRAIN;
            S_DRAIN: if (w_pop && r_head.eop) w_next = S_ACK;
            S_ACK:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Address counter and one-deep read pipe tracking the word the buffer returns next cycle.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            r_addr     <= '0;
            r_infl     <= 1'b0;
            r_infl_sop <= 1'b0;
            r_infl_eop <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_next == S_READ)
                r_addr <= '0;
            else if (w_issue && r_addr != ADDR_LAST)
                r_addr <= r_addr + ADDR_WIDTH'(1);
            r_infl     <= w_issue;
            r_infl_sop <= (r_addr == '0);
            r_infl_eop <= (r_addr == ADDR_LAST);
        end
    end

    // Two-entry skid FIFO; the head register drives the downstream outputs directly.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            r_head     <= '0;
            r_skid     <= '0;
            r_head_vld <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (w_pop || !r_head_vld) begin
            if (r_skid_vld) begin
                r_head     <= r_skid;
                r_head_vld <= 1'b1;
                r_skid_vld <= r_infl;
                if (r_infl) r_skid <= w_push;
            end else begin
                r_head_vld <= r_infl;
                if (r_infl) r_head <= w_push;
            end
        end else if (r_infl) begin
            r_skid     <= w_push;
            r_skid_vld <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            r_rdack     <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_rdack <= (w_next == S_ACK);
            r_busy  <= (w_next != S_IDLE);
            if (w_next == S_ACK) r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign io.buf_rdaddr = r_addr;
    assign io.buf_rdack  = r_rdack;
    assign io.out_Re     = r_head.re;
    assign io.out_Im     = r_head.im;
    assign io.out_valid  = r_head_vld;
    assign io.out_sop    = r_head.sop;
    assign io.out_eop    = r_head.eop;
    assign io.busy       = r_busy;
    assign io.frame_cnt  = r_frame_cnt;
endmodule

// File: tb/tb_cascade_rdseq.sv
// Directed bench for cascade_rdseq with N=8 and a one-cycle-latency buffer model
// holding Re=k, Im=-k at address k.
module tb_cascade_rdseq;
    localparam int unsigned AW = 3;
    localparam int unsigned DW = 32;
    localparam int unsigned NW = 8;

    logic clk = 1'b0;
    logic aclr_n;
    int   checks = 0;
    int   errors = 0;
    int   exp_fc = 0;
    logic signed [DW-1:0] mem_re [NW];
    logic signed [DW-1:0] mem_im [NW];

    cascade_rdseq_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    cascade_rdseq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut (
        .clk    (clk),
        .aclr_n (aclr_n),
        .io     (bus)
    );

    always #5 clk = ~clk;

    // Buffer model: data for the presented address appears the following cycle.
    always @(posedge clk) begin
        bus.buf_Re <= mem_re[bus.buf_rdaddr];
        bus.buf_Im <= mem_im[bus.buf_rdaddr];
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Collect one whole frame from the current cycle on, then check the rdack pulse.
    task automatic collect(input bit toggle, input string tag);
        int idx = 0;
        int cyc = 0;
        bit stall = 1'b0;
        logic [DW-1:0] p_re = '0;
        logic [DW-1:0] p_im = '0;
        logic p_sop = 1'b0;
        logic p_eop = 1'b0;
        while (idx < int'(NW) && cyc < 200) begin
            if (toggle) bus.out_ready = ~bus.out_ready;
            if (stall) begin
                chkb({tag, " hold_valid"}, bus.out_valid, 1'b1);
                chkw({tag, " hold_re"}, bus.out_Re, p_re);
                chkw({tag, " hold_im"}, bus.out_Im, p_im);
                chkb({tag, " hold_sop"}, bus.out_sop, p_sop);
                chkb({tag, " hold_eop"}, bus.out_eop, p_eop);
            end
            chkb({tag, " no_early_rdack"}, bus.buf_rdack, 1'b0);
            if (bus.out_valid && bus.out_ready) begin
                chkw({tag, " re"}, bus.out_Re, 32'(idx));
                chkw({tag, " im"}, bus.out_Im, 32'(-idx));
                chkb({tag, " sop"}, bus.out_sop, idx == 0);
                chkb({tag, " eop"}, bus.out_eop, idx == int'(NW) - 1);
                idx++;
            end
            stall = bus.out_valid && !bus.out_ready;
            p_re  = bus.out_Re;
            p_im  = bus.out_Im;
            p_sop = bus.out_sop;
            p_eop = bus.out_eop;
            step();
            cyc++;
        end
        chkw({tag, " word_count"}, 32'(idx), 32'(NW));
        exp_fc++;
        chkb({tag, " rdack"}, bus.buf_rdack, 1'b1);
        chkw({tag, " frame_cnt"}, 32'(bus.frame_cnt), 32'(16'(exp_fc)));
        step();
        chkb({tag, " rdack_one_cycle"}, bus.buf_rdack, 1'b0);
        chkb({tag, " idle"}, bus.busy, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < int'(NW); k++) begin
            mem_re[k] = 32'(k);
            mem_im[k] = 32'(-k);
        end
        aclr_n        = 1'b0;
        bus.buf_ready = 1'b0;
        bus.out_ready = 1'b1;
        step();
        step();
        chkw("rst rdaddr", 32'(bus.buf_rdaddr), 32'd0);
        chkb("rst rdack", bus.buf_rdack, 1'b0);
        chkb("rst valid", bus.out_valid, 1'b0);
        chkb("rst sop", bus.out_sop, 1'b0);
        chkb("rst eop", bus.out_eop, 1'b0);
        chkw("rst re", bus.out_Re, 32'd0);
        chkb("rst busy", bus.busy, 1'b0);
        chkw("rst frame_cnt", 32'(bus.frame_cnt), 32'd0);
        aclr_n = 1'b1;
        step();
        step();

        // Full-rate frame: sop cycle 3, eop cycle 10, rdack cycle 11.
        bus.buf_ready = 1'b1;
        step();
        bus.buf_ready = 1'b0;
        chkw("t1 addr_c1", 32'(bus.buf_rdaddr), 32'd0);
        chkb("t1 busy_c1", bus.busy, 1'b1);
        chkb("t1 valid_c1", bus.out_valid, 1'b0);
        step();
        chkw("t1 addr_c2", 32'(bus.buf_rdaddr), 32'd1);
        chkb("t1 valid_c2", bus.out_valid, 1'b0);
        step();
        for (int c = 3; c <= 10; c++) begin
            chkb("t1 valid", bus.out_valid, 1'b1);
            chkw("t1 re", bus.out_Re, 32'(c - 3));
            chkw("t1 im", bus.out_Im, 32'(3 - c));
            chkb("t1 sop", bus.out_sop, c == 3);
            chkb("t1 eop", bus.out_eop, c == 10);
            chkb("t1 rdack_low", bus.buf_rdack, 1'b0);
            if (c < 10) step();
        end
        step();
        exp_fc++;
        chkb("t1 rdack_c11", bus.buf_rdack, 1'b1);
        chkw("t1 frame_cnt", 32'(bus.frame_cnt), 32'(exp_fc));
        chkb("t1 valid_c11", bus.out_valid, 1'b0);
        step();
        chkb("t1 rdack_c12", bus.buf_rdack, 1'b0);
        chkb("t1 busy_c12", bus.busy, 1'b0);
        chkw("t1 addr_hold", 32'(bus.buf_rdaddr), 32'd7);
        step();

        // Alternating backpressure.
        bus.buf_ready = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.buf_ready = 1'b0;
        collect(1'b1, "t2");
        bus.out_ready = 1'b1;
        step();

        // Downstream stalled for 20 cycles: issue stops after two addresses.
        bus.buf_ready = 1'b1;
        bus.out_ready = 1'b0;
        step();
        bus.buf_ready = 1'b0;
        for (int c = 1; c < 20; c++) step();
        chkw("t3 addr_stall", 32'(bus.buf_rdaddr), 32'd2);
        chkb("t3 valid_stall", bus.out_valid, 1'b1);
        chkw("t3 re_stall", bus.out_Re, 32'd0);
        chkb("t3 sop_stall", bus.out_sop, 1'b1);
        chkb("t3 busy_stall", bus.busy, 1'b1);
        bus.out_ready = 1'b1;
        collect(1'b0, "t3");
        step();

        // buf_ready held across rdack: second sop four cycles after the first rdack.
        bus.buf_ready = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 11; c++) step();
        exp_fc++;
        chkb("t4 rdack1", bus.buf_rdack, 1'b1);
        chkw("t4 frame_cnt1", 32'(bus.frame_cnt), 32'(exp_fc));
        step();
        chkb("t4 rdack1_low", bus.buf_rdack, 1'b0);
        step();
        bus.buf_ready = 1'b0;
        chkb("t4 busy_restart", bus.busy, 1'b1);
        chkw("t4 addr_restart", 32'(bus.buf_rdaddr), 32'd0);
        step();
        chkb("t4 no_early_sop", bus.out_valid, 1'b0);
        step();
        chkb("t4 sop_valid", bus.out_valid, 1'b1);
        chkb("t4 sop", bus.out_sop, 1'b1);
        collect(1'b0, "t4b");
        step();

        // Reset at word 4: everything clears, no rdack, frame restarts from address 0.
        bus.buf_ready = 1'b1;
        for (int c = 0; c < 7; c++) step();
        chkw("t5 re_word4", bus.out_Re, 32'd4);
        aclr_n = 1'b0;
        #1;
        exp_fc = 0;
        chkb("t5 valid_rst", bus.out_valid, 1'b0);
        chkw("t5 re_rst", bus.out_Re, 32'd0);
        chkw("t5 addr_rst", 32'(bus.buf_rdaddr), 32'd0);
        chkb("t5 busy_rst", bus.busy, 1'b0);
        chkw("t5 frame_cnt_rst", 32'(bus.frame_cnt), 32'd0);
        step();
        chkb("t5 rdack_rst", bus.buf_rdack, 1'b0);
        step();
        aclr_n = 1'b1;
        step();
        bus.buf_ready = 1'b0;
        chkw("t5 addr_restart", 32'(bus.buf_rdaddr), 32'd0);
        collect(1'b0, "t5");
        step();

        // frame_cnt wrap from 0xFFFF.
        force u_dut.r_frame_cnt = 16'hFFFF;
        step();
        release u_dut.r_frame_cnt;
        step();
        exp_fc = 32'hFFFF;
        chkw("t6 preset", 32'(bus.frame_cnt), 32'hFFFF);
        bus.buf_ready = 1'b1;
        step();
        bus.buf_ready = 1'b0;
        collect(1'b0, "t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
